// File: rtl/rx_bit_engine_if.sv
// rx_bit_engine_if: receive state machine and host signals of the receive bit engine
interface rx_bit_engine_if #(parameter int CNT_W = 20);
  logic RX, START, DOIT, EIGHT, PEN, OHEL, READ;
  logic [CNT_W-1:0] BAUD_K;
  logic BTU, DONE, RX_RDY, PERR, FERR, OVF;
  logic [7:0] RX_DATA;
  modport master (
    output RX, START, DOIT, BAUD_K, EIGHT, PEN, OHEL, READ,
    input  BTU, DONE, RX_DATA, RX_RDY, PERR, FERR, OVF
  );
  modport slave (
    input  RX, START, DOIT, BAUD_K, EIGHT, PEN, OHEL, READ,
    output BTU, DONE, RX_DATA, RX_RDY, PERR, FERR, OVF
  );
endinterface

// File: rtl/rx_bit_engine.sv
// rx_bit_engine: bit timing, sampling, frame decode and sticky status for a UART receiver
module rx_bit_engine #(parameter int CNT_W = 20) (
  input logic clk,
  input logic reset,
  rx_bit_engine_if.slave bus
);
  logic [CNT_W-1:0] k_q, k_d, bt_cnt_q, bt_cnt_d, limit;
  logic eight_q, eight_d, pen_q, pen_d, ohel_q, ohel_d;
  logic [3:0] bit_cnt_q, bit_cnt_d, n;
  logic [10:0] sh_q, sh_d, frame;
  logic [7:0] data_q, data_d, dbits;
  logic rdy_q, rdy_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic btu, done, adv, perr_new, ferr_new, keep;
  always_comb begin
    limit = bus.START ? k_q >> 1 : k_q;
    btu = bus.DOIT & (bt_cnt_q == limit);
    n = (eight_q ? 4'd10 : 4'd9) + {3'd0, pen_q};
    done = bus.DOIT & (bit_cnt_q == n);
    adv = btu & ~done;
    // oldest sample sits at bit 11-n after n shifts; realign so start is bit 0
    frame = sh_q >> (4'd11 - n);
    dbits = eight_q ? frame[8:1] : {1'b0, frame[7:1]};
    perr_new = pen_q & ((^dbits ^ frame[n - 4'd2]) != ohel_q);
    ferr_new = ~frame[n - 4'd1];
    keep = ~bus.READ;
    {k_d, eight_d, pen_d, ohel_d} = bus.DOIT ? {k_q, eight_q, pen_q, ohel_q}
                                             : {bus.BAUD_K, bus.EIGHT, bus.PEN, bus.OHEL};
    bt_cnt_d = (~bus.DOIT | btu) ? '0 : bt_cnt_q + CNT_W'(1);
    bit_cnt_d = ~bus.DOIT ? 4'd0 : bit_cnt_q + {3'd0, adv};
    sh_d = adv ? {bus.RX, sh_q[10:1]} : sh_q;
    data_d = done ? dbits : data_q;
    rdy_d = done | (rdy_q & keep);
    perr_d = (done & perr_new) | (perr_q & keep);
    ferr_d = (done & ferr_new) | (ferr_q & keep);
    ovf_d = (ovf_q | (done & rdy_q)) & keep;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {k_q, eight_q, pen_q, ohel_q} <= '0;
      bt_cnt_q <= '0;
      bit_cnt_q <= 4'd0;
      sh_q <= 11'h7FF;
      data_q <= 8'h00;
      {rdy_q, perr_q, ferr_q, ovf_q} <= 4'b0;
    end else begin
      {k_q, eight_q, pen_q, ohel_q} <= {k_d, eight_d, pen_d, ohel_d};
      bt_cnt_q <= bt_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q <= sh_d;
      data_q <= data_d;
      {rdy_q, perr_q, ferr_q, ovf_q} <= {rdy_d, perr_d, ferr_d, ovf_d};
    end
  end
  assign bus.BTU = btu;
  assign bus.DONE = done;
  assign bus.RX_DATA = data_q;
  assign bus.RX_RDY = rdy_q;
  assign bus.PERR = perr_q;
  assign bus.FERR = ferr_q;
  assign bus.OVF = ovf_q;
endmodule

// File: tb/tb_rx_bit_engine.sv
// tb_rx_bit_engine: drives serial frames through a behavioural receive state machine
// and compares decoded data and status against a frame-level reference model
module tb_rx_bit_engine;
  localparam int CNT_W = 20;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0, errors = 0, cyc = 0, sm = 0;
  int done_cnt = 0, btu_n = 0, doit_cyc = 0;
  int btu_t [3];
  bit line_q[$];
  logic [CNT_W-1:0] cfg_k = CNT_W'(15);
  bit cfg_eight = 1'b1, cfg_pen = 1'b0, cfg_ohel = 1'b0;
  bit rd_pulse = 1'b0, rd_on_done = 1'b0, rd_hit = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit m_rdy = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0;

  always #5 clk = ~clk;

  rx_bit_engine_if #(.CNT_W(CNT_W)) bus ();
  rx_bit_engine #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string pfx);
    chk({pfx, ".data"}, 32'(bus.RX_DATA), 32'(m_data));
    chk({pfx, ".rdy"}, 32'(bus.RX_RDY), 32'(m_rdy));
    chk({pfx, ".perr"}, 32'(bus.PERR), 32'(m_perr));
    chk({pfx, ".ferr"}, 32'(bus.FERR), 32'(m_ferr));
    chk({pfx, ".ovf"}, 32'(bus.OVF), 32'(m_ovf));
  endtask

  // config inputs are scrambled mid-frame; the engine must keep its latched copy
  task automatic drive_cfg();
    if (bus.DOIT) begin
      bus.BAUD_K = CNT_W'($urandom);
      bus.EIGHT = 1'($urandom);
      bus.PEN = 1'($urandom);
      bus.OHEL = 1'($urandom);
    end else begin
      bus.BAUD_K = cfg_k;
      bus.EIGHT = cfg_eight;
      bus.PEN = cfg_pen;
      bus.OHEL = cfg_ohel;
    end
  endtask

  task automatic step();
    logic btu, done, rx;
    int prev;
    @(negedge clk);
    btu = bus.BTU;
    done = bus.DONE;
    rx = bus.RX;
    if (done) done_cnt++;
    if (btu && btu_n < 3) begin
      btu_t[btu_n] = cyc;
      btu_n++;
    end
    @(posedge clk);
    #1;
    cyc++;
    prev = sm;
    if (sm == 0 && !rx) sm = 1;
    else if (sm == 1 && btu) sm = rx ? 0 : 2;
    else if (sm == 2 && done) sm = 0;
    bus.START = (sm == 1);
    bus.DOIT = (sm != 0);
    if (prev == 0 && sm != 0) doit_cyc = cyc;
    bus.RX = line_q.size() > 0 ? line_q.pop_front() : 1'b1;
    drive_cfg();
    bus.READ = rd_pulse;
    rd_pulse = 1'b0;
    if (rd_on_done) begin
      #1;
      if (bus.DONE) begin
        bus.READ = 1'b1;
        rd_on_done = 1'b0;
        rd_hit = 1'b1;
      end
    end
  endtask

  task automatic model_capture(input logic [7:0] d, input bit pe, input bit fe, input bit rd);
    if (rd) begin
      m_ovf = 1'b0;
      m_perr = pe;
      m_ferr = fe;
    end else begin
      m_ovf = m_ovf | m_rdy;
      m_perr = m_perr | pe;
      m_ferr = m_ferr | fe;
    end
    m_rdy = 1'b1;
    m_data = d;
  endtask

  task automatic push_frame(input logic [7:0] dm, input int k, input bit e, input bit p,
                            input bit pb, input bit stop);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < (e ? 8 : 7); i++) bits.push_back(dm[i]);
    if (p) bits.push_back(pb);
    bits.push_back(stop);
    foreach (bits[i]) repeat (k + 1) line_q.push_back(bits[i]);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] d, input int k, input bit e,
                            input bit p, input bit o, input bit flip, input bit stop, input bit rd);
    logic [7:0] dm;
    int lim;
    cfg_k = CNT_W'(k);
    cfg_eight = e;
    cfg_pen = p;
    cfg_ohel = o;
    dm = e ? d : {1'b0, d[6:0]};
    push_frame(dm, k, e, p, (^dm) ^ o ^ flip, stop);
    done_cnt = 0;
    btu_n = 0;
    rd_on_done = rd;
    rd_hit = 1'b0;
    lim = 12 * (k + 1) + 40;
    while ((line_q.size() > 0 || sm != 0) && lim > 0) begin
      step();
      lim--;
    end
    chk({tag, ".in_time"}, 32'(lim > 0), 1);
    repeat (3) step();
    rd_on_done = 1'b0;
    chk({tag, ".done_cycles"}, done_cnt, 1);
    if (rd) chk({tag, ".read_hit"}, 32'(rd_hit), 1);
    model_capture(dm, p & flip, !stop, rd);
    check_out(tag);
  endtask

  task automatic read_host();
    rd_pulse = 1'b1;
    step();
    step();
    {m_rdy, m_perr, m_ferr, m_ovf} = 4'b0;
    check_out("read");
  endtask

  task automatic false_start();
    int lim;
    cfg_k = CNT_W'(15);
    cfg_eight = 1'b1;
    cfg_pen = 1'b0;
    repeat (3) line_q.push_back(1'b0);
    done_cnt = 0;
    doit_cyc = -1;
    lim = 80;
    while ((line_q.size() > 0 || sm != 0) && lim > 0) begin
      step();
      lim--;
    end
    chk("fs.dropped", 32'(lim > 0), 1);
    chk("fs.started", 32'(doit_cyc >= 0), 1);
    repeat (3) step();
    chk("fs.no_done", done_cnt, 0);
    check_out("fs");
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, ".data"}, 32'(bus.RX_DATA), 0);
    chk({pfx, ".rdy"}, 32'(bus.RX_RDY), 0);
    chk({pfx, ".perr"}, 32'(bus.PERR), 0);
    chk({pfx, ".ferr"}, 32'(bus.FERR), 0);
    chk({pfx, ".ovf"}, 32'(bus.OVF), 0);
    chk({pfx, ".btu"}, 32'(bus.BTU), 0);
    chk({pfx, ".done"}, 32'(bus.DONE), 0);
  endtask

  task automatic reset_mid_frame();
    cfg_k = CNT_W'(15);
    cfg_eight = 1'b1;
    cfg_pen = 1'b0;
    push_frame(8'h00, 15, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (16 * 4 + 8) step();
    chk("rst.mid_frame", 32'(sm), 2);
    #1;
    reset = 1'b0;
    bus.DOIT = 1'b0;
    bus.START = 1'b0;
    bus.RX = 1'b1;
    sm = 0;
    line_q.delete();
    #1;
    check_zero("rst_mid");
    m_data = 8'h00;
    {m_rdy, m_perr, m_ferr, m_ovf} = 4'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.RX = 1'b1;
    bus.START = 1'b0;
    bus.DOIT = 1'b0;
    bus.READ = 1'b0;
    drive_cfg();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) step();
    send_frame("a5_8n1", 8'hA5, 15, 1, 0, 0, 0, 1, 0);
    chk("btu_first", btu_t[0] - doit_cyc, 7);
    chk("btu_period1", btu_t[1] - btu_t[0], 16);
    chk("btu_period2", btu_t[2] - btu_t[1], 16);
    read_host();
    send_frame("41_7e1_bad", 8'h41, 15, 0, 1, 0, 1, 1, 0);
    read_host();
    send_frame("3c_8o1_ferr", 8'h3C, 15, 1, 1, 1, 0, 0, 0);
    read_host();
    send_frame("ovf_first", 8'h12, 15, 1, 0, 0, 0, 1, 0);
    send_frame("ovf_second", 8'h34, 15, 1, 0, 0, 0, 1, 0);
    send_frame("read_capture", 8'h56, 15, 1, 0, 0, 0, 1, 1);
    false_start();
    send_frame("5a_after_fs", 8'h5A, 15, 1, 0, 0, 0, 1, 0);
    reset_mid_frame();
    repeat (3) step();
    send_frame("ff_after_rst", 8'hFF, 15, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 30; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) false_start();
      else if (r == 1) read_host();
      else send_frame("rand", 8'($urandom), int'($urandom_range(2, 20)), 1'($urandom),
                      1'($urandom), 1'($urandom), ($urandom % 3) == 0, ($urandom % 5) != 0,
                      ($urandom % 4) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
